// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scan controller: render FSM states,
// CSR word indices and STATUS bit positions.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } render_state_t;

  localparam logic [2:0] CSR_CTRL      = 3'd0;
  localparam logic [2:0] CSR_STATUS    = 3'd1;
  localparam logic [2:0] CSR_IRQ       = 3'd2;
  localparam logic [2:0] CSR_UNDERRUN  = 3'd3;
  localparam logic [2:0] CSR_FRAME_CNT = 3'd4;

  localparam int ST_Y_LSB        = 0;
  localparam int ST_X_LSB        = 10;
  localparam int ST_VBLANK_BIT   = 24;
  localparam int ST_UNDERRUN_BIT = 25;
  localparam int ST_BUF_SEL_BIT  = 26;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel phase / x / y counters with sync, blank and line/frame event strobes.
// run=0 zeroes the counters; enable=0 forces syncs inactive and blanks.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        enable,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        line_end,
  output logic        frame_end,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic        vga_clk,
  output logic        pix_valid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [1:0]  PH_LAST = 2'(CLK_DIV - 1);
  localparam logic [1:0]  PH_HALF = 2'(CLK_DIV / 2);
  localparam logic [10:0] X_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);

  logic [1:0] phase;
  logic       ph_last, hs_on, vs_on, active;

  assign ph_last = (phase == PH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else if (!run) begin
      phase <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else if (ph_last) begin
      phase <= '0;
      if (pix_x == X_LAST) begin
        pix_x <= '0;
        pix_y <= (pix_y == Y_LAST) ? 10'd0 : pix_y + 10'd1;
      end else begin
        pix_x <= pix_x + 11'd1;
      end
    end else begin
      phase <= phase + 2'd1;
    end
  end

  assign hs_on = enable && (pix_x >= 11'(H_ACTIVE + H_FP)) &&
                 (pix_x < 11'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on = enable && (pix_y >= 10'(V_ACTIVE + V_FP)) &&
                 (pix_y < 10'(V_ACTIVE + V_FP + V_SYNC));
  assign active = enable && (pix_x < 11'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));

  assign hs         = hs_on ? HS_POL : ~HS_POL;
  assign vs         = vs_on ? VS_POL : ~VS_POL;
  assign blank_n    = active;
  assign pix_valid  = active && (phase == 2'd0);
  // With CLK_DIV=1 PH_HALF is 0, so this is constant 1 as intended.
  assign vga_clk    = (phase >= PH_HALF);
  assign line_start = enable && (phase == 2'd0) && (pix_x == 11'd0);
  assign line_end   = enable && ph_last && (pix_x == X_LAST);
  assign frame_end  = line_end && (pix_y == Y_LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: timing, ping-pong line-buffer render sequencing of
// N_ENG engines, and a small CSR block with frame/underrun status and IRQ.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter int   N_ENG    = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic [2:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [N_ENG-1:0] eng_start,
  input  logic [N_ENG-1:0] eng_done,
  output logic [9:0]       render_line,
  output logic             buf_sel,
  output logic [10:0]      pix_x,
  output logic [9:0]       pix_y,
  output logic             pix_valid,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_n,
  output logic             VGA_SYNC_n,
  output logic             VGA_CLK,
  output logic             irq,
  output render_state_t    fsm_state
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [1:0]       IDX_LAST = 2'(N_ENG - 1);
  localparam logic [N_ENG-1:0] ENG_ONE  = N_ENG'(1);

  render_state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        ctrl_enable, ctrl_irq_en, enable_nxt, run;
  logic        irq_pending, underrun_sticky;
  logic [15:0] underrun_cnt;
  logic [31:0] frame_cnt, rd_mux;
  logic        csr_wr, csr_rd, line_start, line_end, frame_end;
  logic        trigger, swap, irq_set, done_hit;
  logic [9:0]  next_line;

  assign csr_wr = chipselect && write;
  assign csr_rd = chipselect && !write;
  // Disabling zeroes counters on the very write edge; enabling starts from zero.
  assign enable_nxt = (csr_wr && address == CSR_CTRL) ? writedata[0] : ctrl_enable;
  assign run        = ctrl_enable && enable_nxt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .reset(reset), .run(run), .enable(ctrl_enable),
    .pix_x(pix_x), .pix_y(pix_y), .line_start(line_start), .line_end(line_end),
    .frame_end(frame_end), .hs(VGA_HS), .vs(VGA_VS), .blank_n(VGA_BLANK_n),
    .vga_clk(VGA_CLK), .pix_valid(pix_valid)
  );

  assign next_line = (pix_y == Y_LAST) ? 10'd0 : pix_y + 10'd1;
  assign trigger   = run && line_start && (next_line < 10'(V_ACTIVE));
  assign swap      = run && line_end && (next_line < 10'(V_ACTIVE));
  assign irq_set   = run && line_start && (pix_y == 10'(V_ACTIVE));
  assign done_hit  = |(eng_done & (ENG_ONE << idx));

  // Engine handshake: eng_start[idx] pulses once, then only eng_done[idx] advances.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    eng_start = '0;
    unique case (state)
      ST_IDLE: if (trigger) begin
        state_nxt = ST_START;
        idx_nxt   = 2'd0;
      end
      ST_START: begin
        eng_start = ENG_ONE << idx;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (done_hit) begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_START;
          idx_nxt   = idx + 2'd1;
        end
      end
      ST_DONE: ;
      default: state_nxt = ST_IDLE;
    endcase
    if (swap) state_nxt = ST_IDLE;
    if (!run) begin
      state_nxt = ST_IDLE;
      idx_nxt   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      render_line     <= '0;
      buf_sel         <= 1'b0;
      ctrl_enable     <= 1'b0;
      ctrl_irq_en     <= 1'b0;
      irq_pending     <= 1'b0;
      underrun_cnt    <= '0;
      underrun_sticky <= 1'b0;
      frame_cnt       <= '0;
      readdata        <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (trigger) render_line <= next_line;
      if (swap && state == ST_DONE) buf_sel <= ~buf_sel;
      if (csr_wr && address == CSR_CTRL) begin
        ctrl_enable <= writedata[0];
        ctrl_irq_en <= writedata[1];
      end
      if (irq_set) irq_pending <= 1'b1;
      else if (csr_wr && address == CSR_IRQ && writedata[0]) irq_pending <= 1'b0;
      if (csr_wr && address == CSR_UNDERRUN) begin
        underrun_cnt    <= '0;
        underrun_sticky <= 1'b0;
      end else if (swap && state != ST_DONE) begin
        underrun_sticky <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (frame_end && run) frame_cnt <= frame_cnt + 32'd1;
      if (csr_rd) readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      CSR_CTRL:      rd_mux[1:0] = {ctrl_irq_en, ctrl_enable};
      CSR_STATUS: begin
        rd_mux[ST_Y_LSB +: 10]     = pix_y;
        rd_mux[ST_X_LSB +: 11]     = pix_x;
        rd_mux[ST_VBLANK_BIT]      = (pix_y >= 10'(V_ACTIVE));
        rd_mux[ST_UNDERRUN_BIT]    = underrun_sticky;
        rd_mux[ST_BUF_SEL_BIT]     = buf_sel;
      end
      CSR_IRQ:       rd_mux[0] = irq_pending;
      CSR_UNDERRUN:  rd_mux[15:0] = underrun_cnt;
      CSR_FRAME_CNT: rd_mux = frame_cnt;
      default:       rd_mux = '0;
    endcase
  end

  assign irq        = irq_pending && ctrl_irq_en;
  assign VGA_SYNC_n = 1'b0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl on a tiny 14x7 raster with CLK_DIV=2,
// using an arithmetic raster model and an engine responder with random latency.
module tb_vga_scan_ctrl;
  import vga_pkg::*;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int CLK_DIV = 2, N_ENG = 2;
  localparam logic HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE = H_TOTAL * CLK_DIV;
  localparam int FRAME = LINE * V_TOTAL;

  logic clk, reset, chipselect, write;
  logic [2:0] address;
  logic [31:0] writedata, readdata;
  logic [N_ENG-1:0] eng_start, eng_done;
  logic [9:0] render_line, pix_y;
  logic [10:0] pix_x;
  logic buf_sel, pix_valid, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, irq;
  render_state_t fsm_state;

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  int lat = 3;
  bit withhold = 0;
  int cnt[N_ENG];
  logic [23:0] exp_q[$], obs_q[$];

  vga_scan_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .N_ENG(N_ENG), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .eng_start(eng_start), .eng_done(eng_done), .render_line(render_line),
    .buf_sel(buf_sel), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_SYNC_n(VGA_SYNC_n), .VGA_CLK(VGA_CLK), .irq(irq), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Engine responder: done[i] arrives lat cycles after start[i].
  initial begin
    eng_done = '0;
    for (int i = 0; i < N_ENG; i++) cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = '0;
      if (reset) begin
        for (int i = 0; i < N_ENG; i++) cnt[i] = 0;
      end else begin
        for (int i = 0; i < N_ENG; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) eng_done[i] = 1'b1;
          end
        end
        for (int i = 0; i < N_ENG; i++)
          if (eng_start[i] && !(withhold && i == N_ENG - 1 && render_line == 10'd2))
            cnt[i] = lat;
      end
    end
  end

  // Driver tasks
  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; write = 1'b0; address = a;
    tick();
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic enable_dut(input logic [31:0] ctrl);
    csr_write(CSR_CTRL, ctrl);
    t0 = cyc;
  endtask

  task automatic wait_off(input int period, input int off);
    for (int i = 0; i <= period; i++) begin
      if ((cyc - t0) % period == off) break;
      tick();
    end
    checks++;
    if ((cyc - t0) % period != off) begin
      errors++;
      $display("FAIL wait_off: got %0d expected %0d", (cyc - t0) % period, off);
    end
  endtask

  // Reference raster model: position follows directly from cycles since enable.
  function automatic int m_x(input int t); return (t / CLK_DIV) % H_TOTAL; endfunction
  function automatic int m_y(input int t); return (t / LINE) % V_TOTAL; endfunction
  function automatic int m_ph(input int t); return t % CLK_DIV; endfunction
  // Bank flips at every completed line whose successor is a visible line.
  function automatic int m_buf(input int t);
    int n = 0;
    for (int k = 1; k <= t / LINE; k++) if ((k % V_TOTAL) < V_ACTIVE) n++;
    return n % 2;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (pix_x !== 11'd0 || pix_y !== 10'd0) begin errors++;
      $display("FAIL reset_xy: got %0d,%0d expected 0,0", pix_x, pix_y); end
    checks++; if (VGA_HS !== ~HS_POL || VGA_VS !== ~VS_POL) begin errors++;
      $display("FAIL reset_sync: got %b%b expected inactive", VGA_HS, VGA_VS); end
    checks++; if (VGA_BLANK_n !== 1'b0 || VGA_SYNC_n !== 1'b0) begin errors++;
      $display("FAIL reset_blank: got %b%b expected 00", VGA_BLANK_n, VGA_SYNC_n); end
    checks++; if (eng_start !== '0 || buf_sel !== 1'b0 || irq !== 1'b0) begin errors++;
      $display("FAIL reset_outs: got %b %b %b expected 0", eng_start, buf_sel, irq); end
    checks++; if (readdata !== 32'd0 || fsm_state !== ST_IDLE) begin errors++;
      $display("FAIL reset_rd: got %h %0d expected 0", readdata, fsm_state); end
    for (int a = 0; a < 6; a++) begin
      csr_read(3'(a), d);
      checks++; if (d !== 32'd0) begin errors++;
        $display("FAIL reset_csr%0d: got %h expected 0", a, d); end
    end
  endtask

  task automatic test_timing();
    int t, x, y, ph;
    logic [31:0] d, e;
    enable_dut(32'd1);
    for (int s = 0; s < 40; s++) begin
      lat = $urandom_range(1, 6);
      repeat ($urandom_range(1, 11)) tick();
      t = cyc - t0; x = m_x(t); y = m_y(t); ph = m_ph(t);
      checks++; if (pix_x !== 11'(x) || pix_y !== 10'(y)) begin errors++;
        $display("FAIL timing_xy t=%0d: got %0d,%0d expected %0d,%0d", t, pix_x, pix_y, x, y); end
      checks++; if (VGA_HS !== ((x >= 10 && x < 12) ? HS_POL : ~HS_POL)) begin errors++;
        $display("FAIL timing_hs x=%0d: got %b", x, VGA_HS); end
      checks++; if (VGA_VS !== ((y == 5) ? VS_POL : ~VS_POL)) begin errors++;
        $display("FAIL timing_vs y=%0d: got %b", y, VGA_VS); end
      checks++; if (VGA_BLANK_n !== (x < H_ACTIVE && y < V_ACTIVE)) begin errors++;
        $display("FAIL timing_blank x=%0d y=%0d: got %b", x, y, VGA_BLANK_n); end
      checks++; if (pix_valid !== (x < H_ACTIVE && y < V_ACTIVE && ph == 0)) begin errors++;
        $display("FAIL timing_valid t=%0d: got %b", t, pix_valid); end
      checks++; if (VGA_CLK !== (ph >= CLK_DIV / 2)) begin errors++;
        $display("FAIL timing_vclk t=%0d: got %b expected %0d", t, VGA_CLK, ph >= 1); end
      checks++; if (buf_sel !== 1'(m_buf(t))) begin errors++;
        $display("FAIL timing_buf t=%0d: got %b expected %0d", t, buf_sel, m_buf(t)); end
    end
    lat = 3;
    csr_read(CSR_STATUS, d);
    t = cyc - t0 - 1;
    e = '0; e[9:0] = 10'(m_y(t)); e[20:10] = 11'(m_x(t));
    e[24] = (m_y(t) >= V_ACTIVE); e[26] = 1'(m_buf(t));
    checks++; if (d !== e) begin errors++;
      $display("FAIL status: got %h expected %h", d, e); end
    csr_read(CSR_FRAME_CNT, d);
    t = cyc - t0 - 1;
    checks++; if (d !== 32'(t / FRAME) || d == 32'd0) begin errors++;
      $display("FAIL frame_cnt: got %0d expected %0d", d, t / FRAME); end
  endtask

  task automatic test_render();
    int t, toggles;
    logic prev;
    logic [31:0] d;
    lat = 3;
    wait_off(FRAME, 0);
    obs_q.delete(); exp_q.delete();
    for (int y = 0; y < V_TOTAL; y++) begin
      if ((y + 1) % V_TOTAL < V_ACTIVE) begin
        exp_q.push_back({4'd1, 10'((y + 1) % V_TOTAL), 8'd1});
        exp_q.push_back({4'd2, 10'((y + 1) % V_TOTAL), 8'(2 + lat)});
      end
    end
    prev = buf_sel; toggles = 0;
    repeat (FRAME) begin
      tick();
      t = cyc - t0;
      if (eng_start != '0) obs_q.push_back({4'(eng_start), render_line, 8'(t % LINE)});
      if (buf_sel != prev) toggles++;
      prev = buf_sel;
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL render_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL render_seq%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (toggles != V_ACTIVE) begin errors++;
      $display("FAIL render_toggles: got %0d expected %0d", toggles, V_ACTIVE); end
    csr_read(CSR_UNDERRUN, d);
    checks++; if (d !== 32'd0) begin errors++;
      $display("FAIL render_underrun: got %0d expected 0", d); end
  endtask

  task automatic test_underrun();
    logic b1;
    logic [31:0] d;
    wait_off(FRAME, 0);
    withhold = 1;
    wait_off(FRAME, LINE + 1);
    b1 = buf_sel;
    wait_off(FRAME, 2 * LINE);
    withhold = 0;
    checks++; if (buf_sel !== b1) begin errors++;
      $display("FAIL underrun_hold: got %b expected %b", buf_sel, b1); end
    wait_off(FRAME, 2 * LINE + 1);
    checks++; if (eng_start !== 2'b01 || render_line !== 10'd3) begin errors++;
      $display("FAIL underrun_next: got %b/%0d expected 01/3", eng_start, render_line); end
    wait_off(FRAME, 3 * LINE);
    checks++; if (buf_sel !== ~b1) begin errors++;
      $display("FAIL underrun_recover: got %b expected %b", buf_sel, ~b1); end
    csr_read(CSR_UNDERRUN, d);
    checks++; if (d !== 32'd1) begin errors++;
      $display("FAIL underrun_cnt: got %0d expected 1", d); end
    csr_read(CSR_STATUS, d);
    checks++; if (d[25] !== 1'b1) begin errors++;
      $display("FAIL underrun_sticky: got %b expected 1", d[25]); end
    csr_write(CSR_UNDERRUN, $urandom);
    csr_read(CSR_UNDERRUN, d);
    checks++; if (d !== 32'd0) begin errors++;
      $display("FAIL underrun_clear: got %0d expected 0", d); end
    csr_read(CSR_STATUS, d);
    checks++; if (d[25] !== 1'b0) begin errors++;
      $display("FAIL underrun_sticky_clear: got %b expected 0", d[25]); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    csr_write(CSR_IRQ, 32'd1);
    csr_write(CSR_CTRL, 32'd3);
    wait_off(FRAME, V_ACTIVE * LINE);
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL irq_before: got %b expected 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || pix_y !== 10'(V_ACTIVE)) begin errors++;
      $display("FAIL irq_rise: got %b y=%0d expected 1 y=4", irq, pix_y); end
    csr_read(CSR_IRQ, d);
    checks++; if (d !== 32'd1) begin errors++;
      $display("FAIL irq_pending: got %0d expected 1", d); end
    wait_off(FRAME, V_ACTIVE * LINE);
    csr_write(CSR_IRQ, 32'd1);
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL irq_set_wins: got %b expected 1", irq); end
    csr_read(CSR_IRQ, d);
    checks++; if (d !== 32'd1) begin errors++;
      $display("FAIL irq_set_wins_rd: got %0d expected 1", d); end
    csr_write(CSR_IRQ, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL irq_clear: got %b expected 0", irq); end
    csr_read(CSR_CTRL, d);
    checks++; if (d !== 32'd3) begin errors++;
      $display("FAIL ctrl_rd: got %0d expected 3", d); end
  endtask

  task automatic test_enable_reset();
    logic b;
    bit found;
    logic [31:0] d;
    wait_off(LINE, 10 + 2 * $urandom_range(0, 4));
    b = buf_sel;
    csr_write(CSR_CTRL, 32'd0);
    checks++; if (pix_x !== 11'd0 || pix_y !== 10'd0 || VGA_BLANK_n !== 1'b0) begin errors++;
      $display("FAIL disable_now: got %0d,%0d,%b expected 0,0,0", pix_x, pix_y, VGA_BLANK_n); end
    repeat (6) tick();
    checks++; if (pix_x !== 11'd0 || buf_sel !== b || eng_start !== '0 || VGA_HS !== ~HS_POL) begin
      errors++; $display("FAIL disable_hold: got x=%0d buf=%b start=%b", pix_x, buf_sel, eng_start); end
    enable_dut(32'd1);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (eng_start[0]) found = 1;
    end
    checks++; if (!found) begin errors++;
      $display("FAIL restart_start: got none expected eng_start[0]"); end
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (pix_x !== 11'd0 || pix_y !== 10'd0 || eng_start !== '0 || fsm_state !== ST_IDLE) begin
      errors++; $display("FAIL abort: got x=%0d start=%b st=%0d", pix_x, eng_start, fsm_state); end
    tick(); tick();
    reset = 1'b0;
    tick();
    csr_read(CSR_UNDERRUN, d);
    checks++; if (d !== 32'd0) begin errors++;
      $display("FAIL abort_underrun: got %0d expected 0", d); end
    enable_dut(32'd1);
    repeat (2 * LINE + 2) tick();
    csr_read(CSR_UNDERRUN, d);
    checks++; if (d !== 32'd0 || buf_sel !== 1'b0) begin errors++;
      $display("FAIL post_abort: got %0d buf=%b expected 0 0", d, buf_sel); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_render();
    test_underrun();
    test_irq();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48; V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: porch and sync lengths in pixels and lines.
REQ-003 SHALL have parameter CLK_DIV, default 2, range 1..4: clk cycles per pixel.
REQ-004 SHALL have parameter N_ENG, default 2, range 1..4: number of render engines run in sequence per line.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0: sync active level.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 chipselect, write  in  1 each  CSR access strobes.
REQ-009 address  in  3  CSR word index.
REQ-010 writedata  in  32  CSR write data.
REQ-011 readdata  out  32  registered CSR read data.
REQ-012 eng_start  out  N_ENG  one-cycle start pulse per engine.
REQ-013 eng_done  in  N_ENG  one-cycle completion pulse per engine.
REQ-014 render_line  out  10  line index the engines must render.
REQ-015 buf_sel  out  1  line-buffer bank being displayed; engines write bank ~buf_sel.
REQ-016 pix_x  out  11 and pix_y  out  10  current pixel coordinate.
REQ-017 pix_valid  out  1  high in the active area on the first clk of each pixel.
REQ-018 VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK  out  1 each  video timing; VGA_SYNC_n tied 0.
REQ-019 irq  out  1  level interrupt.

Function
REQ-020 Phase counter SHALL count 0..CLK_DIV-1; pix_x SHALL advance when phase wraps; pix_x SHALL wrap at H_TOTAL-1; pix_y SHALL advance on the pix_x wrap and wrap at V_TOTAL-1.
REQ-021 VGA_CLK SHALL be high for phase >= CLK_DIV/2; for CLK_DIV=1 it SHALL equal ~clk-gated-free constant 1 and consumers use pix_valid.
REQ-022 HS SHALL be active for pix_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS the same for pix_y; the active level SHALL be the POL value.
REQ-023 BLANK_n SHALL be high iff pix_x<H_ACTIVE and pix_y<V_ACTIVE.
REQ-024 Render trigger SHALL occur on the first clk of pix_x=0 when the next line (pix_y+1, wrapping to 0) is < V_ACTIVE; render_line SHALL be set to that next line.
REQ-025 Render FSM states SHALL be IDLE, START, WAIT, DONE: IDLE->START on trigger with idx=0; START pulses eng_start[idx] for 1 cycle ->WAIT; WAIT->START (idx+1) on eng_done[idx]; WAIT->DONE on eng_done[N_ENG-1]; DONE->IDLE at the swap point.
REQ-026 eng_done bits other than eng_done[idx] in WAIT SHALL be ignored.
REQ-027 Swap point SHALL be the last clk of pix_x=H_TOTAL-1 on a rendered line; if the FSM is in DONE, buf_sel SHALL toggle; otherwise buf_sel SHALL hold, the underrun counter SHALL increment, the sticky underrun bit SHALL set, and the FSM SHALL be forced to IDLE.
REQ-028 CSR 0 CTRL (R/W): bit0 enable, bit1 irq_en. While enable=0, the counters, phase and FSM SHALL be held at 0/IDLE, syncs inactive, BLANK_n 0, and buf_sel held. Clearing enable mid-frame SHALL take effect next cycle.
REQ-029 CSR 1 STATUS (RO): [9:0] pix_y, [20:10] pix_x, [24] vblank (pix_y>=V_ACTIVE), [25] sticky underrun, [26] buf_sel.
REQ-030 CSR 2 IRQ: bit0 pending, set on the first clk of pix_y=V_ACTIVE, pix_x=0; writing 1 clears it; simultaneous set and clear SHALL result in set. irq SHALL equal pending AND irq_en.
REQ-031 CSR 3 UNDERRUN: [15:0] saturating at 0xFFFF; any write SHALL clear the count and the sticky bit.
REQ-032 CSR 4 FRAME_CNT: 32-bit, increments on the pix_y wrap, wraps to 0; read-only.
REQ-033 readdata SHALL update 1 clk after a read; unmapped addresses SHALL read 0.

Reset
REQ-034 Reset SHALL clear all counters, CSRs, buf_sel, eng_start, irq and readdata, and set the FSM to IDLE; syncs SHALL be inactive during reset.
REQ-035 Reset asserted mid-render SHALL abort the render with no underrun recorded.

Structure
REQ-036 The shared package vga_pkg SHALL hold the FSM state enum, CSR address constants and the STATUS bit positions.
REQ-037 Timing (phase/x/y counters, sync, blank) SHALL be the sub-module vga_timing_gen; the FSM and CSRs SHALL be in the top.

Verification
REQ-038 Use H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, CLK_DIV=2. Enable -> HS active for pix_x 10..11; line period 28 clks; frame 196 clks; FRAME_CNT=1 after the first frame.
REQ-039 N_ENG=2, engines ack 3 clks after start -> eng_start[0] then eng_start[1] in sequence, buf_sel toggles once per rendered line, UNDERRUN=0.
REQ-040 Withhold eng_done[1] on line 2 -> buf_sel does not toggle, UNDERRUN=1, STATUS[25]=1, and the next line starts normally.
REQ-041 Set irq_en=1 -> irq rises at pix_y=4, pix_x=0; write 1 to CSR 2 in the same cycle as the next set -> pending stays 1.
REQ-042 Clear enable mid-line, then assert reset during WAIT -> counters 0, eng_start 0, UNDERRUN unchanged by the abort.
